// File: rtl/rh_temp_i2c_byte_engine.sv
// Avalon-MM I2C byte engine: one command runs optional START, one byte write/read with ACK,
// and optional STOP on open-drain SCL/SDA enables, with SCL clock-stretch support.
module rh_temp_i2c_byte_engine #(
  parameter logic [15:0] DIV_DEFAULT = 16'd125
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        scl_out,
  output logic        sda_out,
  input  logic        scl_in,
  input  logic        sda_in
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_BYTE  = 3'd2,
    S_ACK   = 3'd3,
    S_STOP  = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  quarter_q, quarter_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] div_q, div_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  tx_q, tx_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        ack_smp_q, ack_smp_d;
  logic        rx_nack_q, rx_nack_d;
  logic        cmd_stop_q, cmd_stop_d;
  logic        cmd_byte_q, cmd_byte_d;
  logic        cmd_write_q, cmd_write_d;
  logic        cmd_ack_q, cmd_ack_d;
  logic        hold_low_q, hold_low_d;
  logic        scl_q, scl_d;
  logic        sda_q, sda_d;

  logic        busy_s;
  logic        cmd_wr_s;
  logic        div_wr_s;
  logic        stretch_s;
  logic        data_s;
  logic [15:0] reload_s;
  logic        unused_wdata_s;

  // Pad levels {scl, sda} for a given phase, quarter and data bit.
  function automatic logic [1:0] line_levels(input state_e st, input logic [1:0] q,
                                             input logic d, input logic hold_low);
    logic [1:0] lv;
    lv = 2'b11;
    case (st)
      S_IDLE:  lv = hold_low ? 2'b01 : 2'b11;
      S_START: begin
        case (q)
          2'd0:    lv = 2'b01;
          2'd1:    lv = 2'b11;
          2'd2:    lv = 2'b10;
          default: lv = 2'b00;
        endcase
      end
      S_BYTE, S_ACK: lv = {q[1], d};
      S_STOP: begin
        case (q)
          2'd0:    lv = 2'b00;
          2'd1:    lv = 2'b10;
          default: lv = 2'b11;
        endcase
      end
      default: lv = 2'b11;
    endcase
    return lv;
  endfunction

  assign busy_s         = (state_q != S_IDLE);
  assign cmd_wr_s       = chipselect && !write_n && (address == 2'd0) && !busy_s;
  assign div_wr_s       = chipselect && !write_n && (address == 2'd2) && !busy_s;
  // A divider of zero behaves as one cycle per quarter.
  assign reload_s       = (div_q == 16'd0) ? 16'd0 : (div_q - 16'd1);
  assign stretch_s      = (quarter_q == 2'd2) && !scl_in;
  assign unused_wdata_s = ^writedata[31:16];

  // Next-state sequencing, quarter timing, bit sampling and next pad levels.
  always_comb begin
    state_d     = state_q;
    quarter_d   = quarter_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    tx_d        = tx_q;
    rx_shift_d  = rx_shift_q;
    rx_data_d   = rx_data_q;
    ack_smp_d   = ack_smp_q;
    rx_nack_d   = rx_nack_q;
    div_d       = div_q;
    cmd_stop_d  = cmd_stop_q;
    cmd_byte_d  = cmd_byte_q;
    cmd_write_d = cmd_write_q;
    cmd_ack_d   = cmd_ack_q;
    hold_low_d  = hold_low_q;
    data_s      = 1'b1;

    if (state_q == S_IDLE) begin
      if (div_wr_s) begin
        div_d = writedata[15:0];
      end else begin
        div_d = div_q;
      end
      if (cmd_wr_s && (|writedata[11:8])) begin
        tx_d        = writedata[7:0];
        cmd_stop_d  = writedata[9];
        cmd_write_d = writedata[10];
        cmd_byte_d  = writedata[10] | writedata[11];
        cmd_ack_d   = writedata[12];
        rx_nack_d   = 1'b0;
        quarter_d   = 2'd0;
        cnt_d       = reload_s;
        bit_d       = 3'd7;
        if (writedata[8]) begin
          state_d = S_START;
        end else if (writedata[10] | writedata[11]) begin
          state_d = S_BYTE;
        end else begin
          state_d = S_STOP;
        end
      end else begin
        state_d = S_IDLE;
      end
    end else if (stretch_s) begin
      cnt_d = cnt_q;
    end else if (cnt_q != 16'd0) begin
      cnt_d = cnt_q - 16'd1;
    end else begin
      cnt_d     = reload_s;
      quarter_d = quarter_q + 2'd1;
      // Input sampled on the last cycle of the SCL-high Q2.
      if (quarter_q == 2'd2) begin
        case (state_q)
          S_BYTE:  rx_shift_d = {rx_shift_q[6:0], sda_in};
          S_ACK:   ack_smp_d  = sda_in;
          default: ack_smp_d  = ack_smp_q;
        endcase
      end else begin
        ack_smp_d = ack_smp_q;
      end
      if (quarter_q == 2'd3) begin
        hold_low_d = (state_q != S_STOP);
        case (state_q)
          S_START: state_d = cmd_byte_q ? S_BYTE : (cmd_stop_q ? S_STOP : S_IDLE);
          S_BYTE: begin
            if (bit_q == 3'd0) begin
              state_d = S_ACK;
            end else begin
              state_d = S_BYTE;
              bit_d   = bit_q - 3'd1;
            end
          end
          S_ACK: begin
            if (cmd_write_q) begin
              rx_nack_d = ack_smp_q;
            end else begin
              rx_data_d = rx_shift_q;
            end
            state_d = cmd_stop_q ? S_STOP : S_IDLE;
          end
          S_STOP:  state_d = S_IDLE;
          default: state_d = S_IDLE;
        endcase
      end else begin
        state_d = state_q;
      end
    end

    case (state_d)
      S_BYTE:  data_s = cmd_write_d ? tx_d[bit_d] : 1'b1;
      S_ACK:   data_s = cmd_write_d ? 1'b1 : cmd_ack_d;
      default: data_s = 1'b1;
    endcase
    {scl_d, sda_d} = line_levels(state_d, quarter_d, data_s, hold_low_d);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      quarter_q   <= 2'd0;
      cnt_q       <= 16'd0;
      div_q       <= DIV_DEFAULT;
      bit_q       <= 3'd7;
      tx_q        <= 8'd0;
      rx_shift_q  <= 8'd0;
      rx_data_q   <= 8'd0;
      ack_smp_q   <= 1'b0;
      rx_nack_q   <= 1'b0;
      cmd_stop_q  <= 1'b0;
      cmd_byte_q  <= 1'b0;
      cmd_write_q <= 1'b0;
      cmd_ack_q   <= 1'b0;
      hold_low_q  <= 1'b0;
      scl_q       <= 1'b1;
      sda_q       <= 1'b1;
    end else begin
      state_q     <= state_d;
      quarter_q   <= quarter_d;
      cnt_q       <= cnt_d;
      div_q       <= div_d;
      bit_q       <= bit_d;
      tx_q        <= tx_d;
      rx_shift_q  <= rx_shift_d;
      rx_data_q   <= rx_data_d;
      ack_smp_q   <= ack_smp_d;
      rx_nack_q   <= rx_nack_d;
      cmd_stop_q  <= cmd_stop_d;
      cmd_byte_q  <= cmd_byte_d;
      cmd_write_q <= cmd_write_d;
      cmd_ack_q   <= cmd_ack_d;
      hold_low_q  <= hold_low_d;
      scl_q       <= scl_d;
      sda_q       <= sda_d;
    end
  end

  assign scl_out = scl_q;
  assign sda_out = sda_q;

  // Zero-wait register read mux.
  always_comb begin
    readdata = 32'd0;
    case (address)
      2'd0:    readdata = {24'd0, rx_data_q};
      2'd1:    readdata = {30'd0, rx_nack_q, busy_s};
      2'd2:    readdata = {16'd0, div_q};
      default: readdata = 32'd0;
    endcase
  end

endmodule
